instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 8, program-counter width; instruction memory holds 2**PC_W bytes.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 prog_valid  input  1  program-load beat valid.
REQ-005 prog_data  input  8  instruction byte for the current load beat.
REQ-006 prog_last  input  1  marks final load beat, qualified by prog_valid.
REQ-007 prog_ready  output  1  block accepts load beats; high only in LOAD.
REQ-008 start  input  1  one-cycle pulse that begins execution at address 0.
REQ-009 pc_load  input  1  from control unit: load PC (branch taken or return).
REQ-010 pc_inc  input  1  from control unit: advance PC by one.
REQ-011 halt  input  1  from control unit: stop execution.
REQ-012 instr  output  8  current instruction byte to control unit.
REQ-013 pc  output  PC_W  current program counter.
REQ-014 running  output  1  high in RUN only.
REQ-015 halted  output  1  high in HALT only.

Function
REQ-016 FSM states: LOAD, IDLE, RUN, HALT.
REQ-017 LOAD: a beat is accepted when prog_valid and prog_ready are both high; byte written to mem[wr_ptr]; wr_ptr increments.
REQ-018 LOAD -> IDLE on an accepted beat with prog_last=1, or on an accepted beat at wr_ptr = 2**PC_W-1 (memory full); prog_len then equals the number of bytes accepted.
REQ-019 IDLE: start=1 -> RUN, pc <= 0; start is ignored in LOAD and RUN.
REQ-020 RUN: instr = mem[pc] combinationally (zero-cycle fetch latency) when pc < prog_len; instr = 8'hFF (HLT) when pc >= prog_len.
REQ-021 In LOAD, IDLE and HALT, instr = 8'h00 (NOP); pc_load, pc_inc and halt are ignored.
REQ-022 RUN next-PC priority: halt > pc_load > pc_inc > hold.
REQ-023 halt=1: go to HALT; pc holds.
REQ-024 pc_load=1 with instr[7:4]=4'b1000 (BR): ret_addr <= pc+1 and pc <= {pc[PC_W-1:4], instr[3:0]} (page-relative target).
REQ-025 pc_load=1 with instr[7:4]=4'b1011 (RET): pc <= ret_addr; ret_addr is unchanged.
REQ-026 pc_load=1 with any other opcode: pc holds; no other effect.
REQ-027 pc_inc=1: pc <= pc+1, modulo 2**PC_W (wraps from all-ones to 0).
REQ-028 HALT: start=1 -> RUN with pc <= 0; memory contents and prog_len are preserved.
REQ-029 ret_addr is a single-entry register; a nested BR overwrites it.

Reset
REQ-030 When rst=1 at a clock edge: state <= LOAD, pc <= 0, wr_ptr <= 0, prog_len <= 0, ret_addr <= 0. Memory contents are not cleared.
REQ-031 Outputs after reset: prog_ready=1, running=0, halted=0, instr=8'h00, pc=0.
REQ-032 Reset asserted mid-load or mid-run takes priority over all other inputs; the partial program is discarded (prog_len=0).

Structure
REQ-033 Opcode nibbles (BR=4'b1000, RET=4'b1011), the HLT byte (8'hFF), the NOP byte (8'h00) and the FSM state encoding are defined in a shared package, together with the control unit's opcode constants.
REQ-034 One sub-module, instr_mem: a 2**PC_W x 8 array with one synchronous write port and one asynchronous read port.

Verification
REQ-035 Load bytes 06,06,FF with prog_last on the third beat; pulse start -> instr sequence 06,06,FF; pc sequence 0,1,2; halted=1 on the cycle after halt is seen.
REQ-036 At pc=0x12, apply instr=0x85 with pc_load=1 -> pc=0x15 and ret_addr=0x13; at the subsequent RET with pc_load=1 -> pc=0x13.
REQ-037 Load 3 bytes with no HLT, then step pc to 3 -> instr=0xFF.
REQ-038 Apply halt=1, pc_load=1 and pc_inc=1 in the same cycle -> HALT is entered and pc is unchanged.
REQ-039 With PC_W=4, load 16 beats without prog_last -> state IDLE after beat 16 and prog_ready=0; pc_inc at pc=0xF -> pc=0x0.
REQ-040 Assert rst during the 2nd load beat and again in RUN -> both cases return to LOAD with pc=0, prog_ready=1 and instr=0x00.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared opcode constants, fixed instruction bytes and fetch FSM encoding
// used by the instruction fetch unit and the control unit that drives it.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  // Control-unit opcode nibbles (instr[7:4]); only BR and RET affect the PC here.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_BR  = 4'b1000;
  localparam logic [3:0] OP_RET = 4'b1011;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [7:0] HLT_BYTE = 8'hFF;
  localparam logic [7:0] NOP_BYTE = 8'h00;

  function automatic logic [3:0] opcode(input logic [7:0] b);
    return b[7:4];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-load port, control-unit strobes and fetch outputs of instr_fetch.
// Load handshake: a beat transfers on a rising clk edge where prog_valid and
// prog_ready are both high; prog_data/prog_last are only meaningful with prog_valid.
interface instr_fetch_if import instr_fetch_pkg::*; #(parameter int PC_W = 8) ();
  logic            prog_valid;
  logic [7:0]      prog_data;
  logic            prog_last;
  logic            prog_ready;
  logic            start;
  logic            pc_load;
  logic            pc_inc;
  logic            halt;
  logic [7:0]      instr;
  logic [PC_W-1:0] pc;
  logic            running;
  logic            halted;
  fetch_state_t    state;
  logic [PC_W-1:0] ret_addr;

  modport master (
    output prog_valid, prog_data, prog_last, start, pc_load, pc_inc, halt,
    input  prog_ready, instr, pc, running, halted, state, ret_addr
  );

  modport slave (
    input  prog_valid, prog_data, prog_last, start, pc_load, pc_inc, halt,
    output prog_ready, instr, pc, running, halted, state, ret_addr
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Byte-wide instruction store: synchronous write, asynchronous read so the
// fetch path has zero-cycle latency. Contents are intentionally not reset.
module instr_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: loads a program byte stream, then supplies mem[pc]
// to the control unit and updates the PC from its halt/branch/step strobes.
module instr_fetch import instr_fetch_pkg::*; #(
  parameter int PC_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);
  localparam logic [PC_W-1:0] PC_MAX    = {PC_W{1'b1}};
  localparam logic [PC_W-1:0] PAGE_MASK = ~PC_W'(15);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] wr_ptr;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W:0]   prog_len;   // one bit wider: a full memory holds 2**PC_W bytes
  logic [7:0]      mem_rdata;
  logic [7:0]      instr;
  logic            prog_ready;
  logic            running;
  logic            halted;
  logic            beat;

  assign beat = bus.prog_valid && prog_ready;

  instr_mem #(.AW(PC_W)) u_mem (
    .clk   (clk),
    .we    (beat),
    .waddr (wr_ptr),
    .wdata (bus.prog_data),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  // Running off the end of the loaded program reads as HLT.
  always_comb begin
    instr = NOP_BYTE;
    if (state == ST_RUN) instr = ({1'b0, pc} < prog_len) ? mem_rdata : HLT_BYTE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      pc         <= '0;
      wr_ptr     <= '0;
      prog_len   <= '0;
      ret_addr   <= '0;
      prog_ready <= 1'b1;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (beat) begin
            wr_ptr <= wr_ptr + PC_W'(1);
            if (bus.prog_last || wr_ptr == PC_MAX) begin
              state      <= ST_IDLE;
              prog_ready <= 1'b0;
              prog_len   <= {1'b0, wr_ptr} + (PC_W+1)'(1);
            end
          end
        end
        ST_IDLE, ST_HALT: begin
          if (bus.start) begin
            state   <= ST_RUN;
            pc      <= '0;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.halt) begin
            state   <= ST_HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (bus.pc_load) begin
            if (opcode(instr) == OP_BR) begin
              ret_addr <= pc + PC_W'(1);
              pc       <= (pc & PAGE_MASK) | PC_W'(instr[3:0]);
            end else if (opcode(instr) == OP_RET) begin
              pc <= ret_addr;
            end
          end else if (bus.pc_inc) begin
            pc <= pc + PC_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.prog_ready = prog_ready;
  assign bus.instr      = instr;
  assign bus.pc         = pc;
  assign bus.running    = running;
  assign bus.halted     = halted;
  assign bus.state      = state;
  assign bus.ret_addr   = ret_addr;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run, checked
// against a behavioural program/PC model; a second 4-bit instance covers wrap and full memory.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(8)) if8 ();
  instr_fetch_if #(.PC_W(4)) if4 ();

  instr_fetch #(.PC_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  instr_fetch #(.PC_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] prog_q[$];

  // reference model of the 8-bit instance; m_mode: 0 load, 1 idle, 2 run, 3 halt
  logic [7:0] m_mem[256];
  int m_pc, m_ret, m_len, m_mode;

  function automatic logic [7:0] m_instr();
    if (m_mode != 2) return 8'h00;
    return (m_pc < m_len) ? m_mem[m_pc] : 8'hFF;
  endfunction

  task automatic model_step(input bit st, input bit ld, input bit inc, input bit h);
    logic [7:0] ei;
    ei = m_instr();
    if (m_mode == 2) begin
      if (h) m_mode = 3;
      else if (ld) begin
        if (ei / 16 == 8) begin
          m_ret = (m_pc + 1) % 256;
          m_pc  = (m_pc / 16) * 16 + ei % 16;
        end else if (ei / 16 == 11) m_pc = m_ret;
      end else if (inc) m_pc = (m_pc + 1) % 256;
    end else if ((m_mode == 1 || m_mode == 3) && st) begin
      m_mode = 2;
      m_pc   = 0;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc = 0; m_ret = 0; m_len = 0; m_mode = 0;
  endtask

  task automatic step8(input bit st, input bit ld, input bit inc, input bit h);
    if8.start = st; if8.pc_load = ld; if8.pc_inc = inc; if8.halt = h;
    model_step(st, ld, inc, h);
    tick();
    if8.start = 1'b0; if8.pc_load = 1'b0; if8.pc_inc = 1'b0; if8.halt = 1'b0;
  endtask

  task automatic load8(input bit use_last);
    for (int i = 0; i < prog_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if8.prog_valid = 1'b0;
        tick();
      end
      if8.prog_valid = 1'b1;
      if8.prog_data  = prog_q[i];
      if8.prog_last  = use_last && (i == prog_q.size() - 1);
      tick();
      m_mem[i] = prog_q[i];
    end
    if8.prog_valid = 1'b0;
    if8.prog_last  = 1'b0;
    m_len  = prog_q.size();
    m_mode = 1;
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 3))
      0:       return {4'b1000, 4'($urandom_range(0, 15))};
      1:       return {4'b1011, 4'($urandom_range(0, 15))};
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // scenarios
  task automatic test_reset();
    do_reset();
    vectors++; if (if8.prog_ready !== 1'b1) begin miscompares++; $display("FAIL rst_prog_ready got %b want 1", if8.prog_ready); end
    vectors++; if (if8.running !== 1'b0) begin miscompares++; $display("FAIL rst_running got %b want 0", if8.running); end
    vectors++; if (if8.halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %b want 0", if8.halted); end
    vectors++; if (if8.instr !== 8'h00) begin miscompares++; $display("FAIL rst_instr got %h want 00", if8.instr); end
    vectors++; if (if8.pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc got %h want 00", if8.pc); end
    vectors++; if (if8.state !== ST_LOAD) begin miscompares++; $display("FAIL rst_state got %0d want %0d", if8.state, ST_LOAD); end
    step8(1, 0, 1, 0);
    vectors++; if (if8.state !== ST_LOAD) begin miscompares++; $display("FAIL start_in_load state got %0d want %0d", if8.state, ST_LOAD); end
  endtask

  task automatic test_basic();
    do_reset();
    prog_q = '{8'h06, 8'h06, 8'hFF};
    load8(1);
    vectors++; if (if8.state !== ST_IDLE) begin miscompares++; $display("FAIL basic_idle state got %0d want %0d", if8.state, ST_IDLE); end
    vectors++; if (if8.prog_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready got %b want 0", if8.prog_ready); end
    step8(0, 0, 1, 0);
    vectors++; if (if8.pc !== 8'h00 || if8.instr !== 8'h00) begin miscompares++; $display("FAIL idle_inc pc/instr got %h/%h want 00/00", if8.pc, if8.instr); end
    step8(1, 0, 0, 0);
    vectors++; if (if8.running !== 1'b1) begin miscompares++; $display("FAIL basic_running got %b want 1", if8.running); end
    exp_q.push_back(8'h06); exp_q.push_back(8'h06); exp_q.push_back(8'hFF);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      vectors++; if (if8.pc !== 8'(k)) begin miscompares++; $display("FAIL basic_pc got %h want %h", if8.pc, 8'(k)); end
      vectors++; if (if8.instr !== e) begin miscompares++; $display("FAIL basic_instr got %h want %h", if8.instr, e); end
      if (k < 2) step8(0, 0, 1, 0);
    end
    step8(0, 0, 0, 1);
    vectors++; if (if8.halted !== 1'b1 || if8.running !== 1'b0) begin miscompares++; $display("FAIL basic_halt halted/running got %b/%b want 1/0", if8.halted, if8.running); end
    vectors++; if (if8.pc !== 8'h02 || if8.instr !== 8'h00) begin miscompares++; $display("FAIL basic_halt pc/instr got %h/%h want 02/00", if8.pc, if8.instr); end
  endtask

  task automatic test_branch();
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 32; i++) prog_q.push_back(8'($urandom_range(0, 255)));
    prog_q[8'h12] = 8'h85;
    prog_q[8'h15] = 8'hB0;
    load8(1);
    step8(1, 0, 0, 0);
    for (int i = 0; i < 8'h12; i++) begin
      vectors++; if (if8.pc !== 8'(m_pc) || if8.instr !== m_instr()) begin miscompares++; $display("FAIL br_walk pc/instr got %h/%h want %h/%h", if8.pc, if8.instr, 8'(m_pc), m_instr()); end
      step8(0, 0, 1, 0);
    end
    vectors++; if (if8.pc !== 8'h12 || if8.instr !== 8'h85) begin miscompares++; $display("FAIL br_at pc/instr got %h/%h want 12/85", if8.pc, if8.instr); end
    step8(0, 1, 0, 0);
    vectors++; if (if8.pc !== 8'h15) begin miscompares++; $display("FAIL br_target got %h want 15", if8.pc); end
    vectors++; if (if8.ret_addr !== 8'h13) begin miscompares++; $display("FAIL br_ret_addr got %h want 13", if8.ret_addr); end
    step8(0, 1, 0, 0);
    vectors++; if (if8.pc !== 8'h13) begin miscompares++; $display("FAIL ret_pc got %h want 13", if8.pc); end
    vectors++; if (if8.ret_addr !== 8'h13) begin miscompares++; $display("FAIL ret_keeps_addr got %h want 13", if8.ret_addr); end
  endtask

  task automatic test_past_end();
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 3; i++) prog_q.push_back(8'($urandom_range(0, 8'hEF)));
    load8(1);
    step8(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (if8.instr !== prog_q[i]) begin miscompares++; $display("FAIL pe_instr got %h want %h", if8.instr, prog_q[i]); end
      step8(0, 0, 1, 0);
    end
    vectors++; if (if8.pc !== 8'h03 || if8.instr !== 8'hFF) begin miscompares++; $display("FAIL pe_hlt pc/instr got %h/%h want 03/ff", if8.pc, if8.instr); end
    step8(0, 1, 0, 0);
    vectors++; if (if8.pc !== 8'h03) begin miscompares++; $display("FAIL pe_other_op pc got %h want 03", if8.pc); end
  endtask

  task automatic test_priority();
    do_reset();
    prog_q = '{8'h01, 8'h84, 8'h02};
    load8(1);
    step8(1, 0, 0, 0);
    step8(0, 0, 1, 0);
    step8(0, 1, 1, 1);
    vectors++; if (if8.state !== ST_HALT || if8.halted !== 1'b1) begin miscompares++; $display("FAIL prio_halt state/halted got %0d/%b want %0d/1", if8.state, if8.halted, ST_HALT); end
    vectors++; if (if8.pc !== 8'h01) begin miscompares++; $display("FAIL prio_pc got %h want 01", if8.pc); end
    step8(0, 0, 1, 0);
    vectors++; if (if8.pc !== 8'h01 || if8.instr !== 8'h00) begin miscompares++; $display("FAIL halt_ignore pc/instr got %h/%h want 01/00", if8.pc, if8.instr); end
    step8(1, 0, 0, 0);
    vectors++; if (if8.running !== 1'b1 || if8.pc !== 8'h00 || if8.instr !== 8'h01) begin miscompares++; $display("FAIL restart run/pc/instr got %b/%h/%h want 1/00/01", if8.running, if8.pc, if8.instr); end
    step8(0, 0, 1, 0); step8(0, 0, 1, 0); step8(0, 0, 1, 0);
    vectors++; if (if8.pc !== 8'h03 || if8.instr !== 8'hFF) begin miscompares++; $display("FAIL restart_len pc/instr got %h/%h want 03/ff", if8.pc, if8.instr); end
  endtask

  task automatic test_full_mem();
    logic [7:0] d4[16];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      d4[i] = 8'($urandom_range(0, 255));
      vectors++; if (if4.prog_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_beat%0d got %b want 1", i, if4.prog_ready); end
      if4.prog_valid = 1'b1; if4.prog_data = d4[i]; if4.prog_last = 1'b0;
      tick();
    end
    if4.prog_valid = 1'b0;
    vectors++; if (if4.state !== ST_IDLE || if4.prog_ready !== 1'b0) begin miscompares++; $display("FAIL full_idle state/ready got %0d/%b want %0d/0", if4.state, if4.prog_ready, ST_IDLE); end
    if4.start = 1'b1; tick(); if4.start = 1'b0;
    for (int p = 0; p < 16; p++) begin
      vectors++; if (if4.pc !== 4'(p) || if4.instr !== d4[p]) begin miscompares++; $display("FAIL full_walk pc/instr got %h/%h want %h/%h", if4.pc, if4.instr, 4'(p), d4[p]); end
      if4.pc_inc = 1'b1; tick(); if4.pc_inc = 1'b0;
    end
    vectors++; if (if4.pc !== 4'h0 || if4.instr !== d4[0]) begin miscompares++; $display("FAIL full_wrap pc/instr got %h/%h want 0/%h", if4.pc, if4.instr, d4[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if8.prog_valid = 1'b1; if8.prog_data = 8'hAA; tick();
    if8.prog_data = 8'hBB; rst = 1'b1; tick();
    rst = 1'b0; if8.prog_valid = 1'b0;
    m_pc = 0; m_ret = 0; m_len = 0; m_mode = 0;
    vectors++; if (if8.state !== ST_LOAD || if8.pc !== 8'h00) begin miscompares++; $display("FAIL midload state/pc got %0d/%h want %0d/00", if8.state, if8.pc, ST_LOAD); end
    vectors++; if (if8.prog_ready !== 1'b1 || if8.instr !== 8'h00) begin miscompares++; $display("FAIL midload ready/instr got %b/%h want 1/00", if8.prog_ready, if8.instr); end
    prog_q = '{8'h05};
    load8(1);
    step8(1, 0, 0, 0);
    vectors++; if (if8.instr !== 8'h05) begin miscompares++; $display("FAIL reload_instr got %h want 05", if8.instr); end
    step8(0, 0, 1, 0);
    vectors++; if (if8.instr !== 8'hFF) begin miscompares++; $display("FAIL reload_len instr got %h want ff", if8.instr); end
    rst = 1'b1; if8.pc_inc = 1'b1; tick(); rst = 1'b0; if8.pc_inc = 1'b0;
    vectors++; if (if8.state !== ST_LOAD || if8.pc !== 8'h00 || if8.running !== 1'b0) begin miscompares++; $display("FAIL midrun state/pc/run got %0d/%h/%b want %0d/00/0", if8.state, if8.pc, if8.running, ST_LOAD); end
    vectors++; if (if8.prog_ready !== 1'b1 || if8.instr !== 8'h00) begin miscompares++; $display("FAIL midrun ready/instr got %b/%h want 1/00", if8.prog_ready, if8.instr); end
  endtask

  task automatic test_random_run();
    for (int r = 0; r < 2; r++) begin
      do_reset();
      prog_q.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++) prog_q.push_back(rand_byte());
      load8(1);
      step8(1, 0, 0, 0);
      for (int c = 0; c < 300; c++) begin
        step8($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 0, $urandom_range(0, 19) == 0);
        vectors++; if (if8.pc !== 8'(m_pc)) begin miscompares++; $display("FAIL rnd_pc cyc%0d got %h want %h", c, if8.pc, 8'(m_pc)); end
        vectors++; if (if8.instr !== m_instr()) begin miscompares++; $display("FAIL rnd_instr cyc%0d got %h want %h", c, if8.instr, m_instr()); end
        vectors++; if (if8.running !== (m_mode == 2)) begin miscompares++; $display("FAIL rnd_running cyc%0d got %b want %b", c, if8.running, m_mode == 2); end
        vectors++; if (if8.halted !== (m_mode == 3)) begin miscompares++; $display("FAIL rnd_halted cyc%0d got %b want %b", c, if8.halted, m_mode == 3); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if8.prog_valid = 1'b0; if8.prog_data = 8'h00; if8.prog_last = 1'b0;
    if8.start = 1'b0; if8.pc_load = 1'b0; if8.pc_inc = 1'b0; if8.halt = 1'b0;
    if4.prog_valid = 1'b0; if4.prog_data = 8'h00; if4.prog_last = 1'b0;
    if4.start = 1'b0; if4.pc_load = 1'b0; if4.pc_inc = 1'b0; if4.halt = 1'b0;
    test_reset();
    test_basic();
    test_branch();
    test_past_end();
    test_priority();
    test_full_mem();
    test_reset_mid();
    test_random_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
